// File: rtl/bmult_pipe.sv
// ----------------------------------------------------------------------------
// bmult_pipe
//   Pipelined WA x WB multiplier with a per-transaction signed/unsigned mode and
//   a valid/ready handshake. The whole pipe advances together. A stall at the
//   output freezes every stage. Bubbles are carried through and never collapsed.
//
//   Parameters
//     WA, WB  : operand widths (>= 2)
//     STAGES  : register stages from input acceptance to P (1..4)
//
//   Ports
//     clk        in   clock, rising edge
//     rst        in   asynchronous active-high reset
//     in_valid   in   A/B/tc carry a transaction
//     in_ready   out  transaction accepted this cycle when in_valid is also 1
//     A          in   multiplicand, WA bits
//     B          in   multiplier, WB bits
//     tc         in   1 = both operands two's complement, 0 = both unsigned
//     out_valid  out  P/P_tc hold a result
//     out_ready  in   downstream takes P this cycle
//     P          out  full-width product, WA+WB bits
//     P_tc       out  tc the current P was computed with
// ----------------------------------------------------------------------------
module bmult_pipe #(
    parameter int WA     = 12,
    parameter int WB     = 12,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WA-1:0]        A,
    input  logic [WB-1:0]        B,
    input  logic                 tc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WA+WB-1:0]     P,
    output logic                 P_tc
);
    localparam int W = WA + WB;
    localparam int H = W / 2;

    logic         adv;
    logic [W-1:0] ext_a;
    logic [W-1:0] ext_b;
    logic [W-1:0] pp_lo;
    logic [W-1:0] pp_hi;

    // Per-stage state, index 0 is the first register after the input.
    logic         vld_q  [STAGES];
    logic         vld_d  [STAGES];
    logic         tc_q   [STAGES];
    logic         tc_d   [STAGES];
    logic [W-1:0] prod_q [STAGES];
    logic [W-1:0] prod_d [STAGES];

    // The only thing that can stop the pipe is a result nobody is taking.
    assign adv      = out_ready || !out_valid;
    assign in_ready = adv;

    // Extending both operands to the full product width makes the product
    // modulo 2^W correct for either mode, so one unsigned array serves both.
    assign ext_a = tc ? {{WB{A[WA-1]}}, A} : {{WB{1'b0}}, A};
    assign ext_b = tc ? {{WA{B[WB-1]}}, B} : {{WA{1'b0}}, B};

    // Two partial products from the low and high halves of ext_b. Their sum
    // modulo 2^W is the product; the addition is the reduction step.
    assign pp_lo = ext_a * {{(W-H){1'b0}}, ext_b[H-1:0]};
    assign pp_hi = ext_a * {ext_b[W-1:H], {H{1'b0}}};

    assign vld_d[0] = in_valid;
    assign tc_d[0]  = tc;

    genvar gi;
    generate
        if (STAGES == 1) begin : g_single
            // Legacy timing: whole product registered once.
            assign prod_d[0] = pp_lo + pp_hi;
        end else begin : g_split
            // Stage 0 holds the low partial product in prod_q[0] and the high
            // one in hi_q; stage 1 adds them.
            logic [W-1:0] hi_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hi_q <= '0;
                end else if (adv) begin
                    hi_q <= pp_hi;
                end
            end

            assign prod_d[0] = pp_lo;
            assign prod_d[1] = prod_q[0] + hi_q;
            assign vld_d[1]  = vld_q[0];
            assign tc_d[1]   = tc_q[0];
        end

        // Remaining stages only delay the finished product.
        for (gi = 2; gi < STAGES; gi++) begin : g_delay
            assign prod_d[gi] = prod_q[gi-1];
            assign vld_d[gi]  = vld_q[gi-1];
            assign tc_d[gi]   = tc_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i]  <= 1'b0;
                tc_q[i]   <= 1'b0;
                prod_q[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                vld_q[i]  <= vld_d[i];
                tc_q[i]   <= tc_d[i];
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign P         = prod_q[STAGES-1];
    assign P_tc      = tc_q[STAGES-1];

endmodule

// File: tb/tb_bmult_pipe.sv
// ----------------------------------------------------------------------------
// tb_bmult_pipe
//   Self-checking bench for bmult_pipe (12x12, 2 stages). Every accepted input
//   pushes an expected {P, tc, accept cycle, stall count} onto a queue; every
//   output transfer pops and compares product, mode and latency. Latency is
//   STAGES plus the number of stalled cycles the transaction sat through.
// ----------------------------------------------------------------------------
module tb_bmult_pipe;
    localparam int WA     = 12;
    localparam int WB     = 12;
    localparam int STAGES = 2;
    localparam int W      = WA + WB;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WA-1:0] A;
    logic [WB-1:0] B;
    logic          tc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  P;
    logic          P_tc;

    always #5 clk = ~clk;

    bmult_pipe #(
        .WA     (WA),
        .WB     (WB),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .tc        (tc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .P_tc      (P_tc)
    );

    typedef struct {
        logic [W-1:0] p;
        logic         t;
        int           it;
        int           st;
    } exp_t;

    exp_t exp_q[$];
    int   total     = 0;
    int   bad       = 0;
    int   iter      = 0;
    int   stall_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference product from plain integer arithmetic on the operand values.
    function automatic logic [W-1:0] model(input logic [WA-1:0] a, input logic [WB-1:0] b,
                                           input logic t);
        longint      sa;
        longint      sb;
        logic [63:0] prod;
        sa = longint'({{(64-WA){1'b0}}, a});
        sb = longint'({{(64-WB){1'b0}}, b});
        if (t && a[WA-1]) sa = sa - (longint'(1) << WA);
        if (t && b[WB-1]) sb = sb - (longint'(1) << WB);
        prod = 64'(sa * sb);
        return prod[W-1:0];
    endfunction

    // One clock cycle: drive at the falling edge, settle, then account for the
    // transfers that the next rising edge will perform.
    task automatic step(input logic iv, input logic [WA-1:0] a, input logic [WB-1:0] b,
                        input logic t, input logic ordy, input logic use_exp,
                        input logic [W-1:0] exp_p);
        exp_t e;
        @(negedge clk);
        in_valid  = iv;
        A         = a;
        B         = b;
        tc        = t;
        out_ready = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'(0));
            end else begin
                e = exp_q.pop_front();
                $display("out cyc=%0d P=0x%0h P_tc=%0d exp=0x%0h", iter, P, P_tc, e.p);
                chk("P", 64'(P), 64'(e.p));
                chk("P_tc", 64'(P_tc), 64'(e.t));
                chk("latency", 64'(iter), 64'(e.it + STAGES + stall_cnt - e.st));
            end
        end
        if (in_valid && in_ready) begin
            e.p  = use_exp ? exp_p : model(a, b, t);
            e.t  = t;
            e.it = iter;
            e.st = stall_cnt;
            exp_q.push_back(e);
        end
        if (!in_ready) stall_cnt++;
        iter++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() > 0; k++)
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        for (int k = 0; k < STAGES + 2; k++)
            step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        tc        = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_P", 64'(P), 64'(0));
        chk("rst_P_tc", 64'(P_tc), 64'(0));
        rst = 1'b0;

        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0);
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));

        // Unsigned maximum.
        step(1'b1, 12'hFFF, 12'hFFF, 1'b0, 1'b1, 1'b1, 24'hFFE001);
        // Signed corners, back to back.
        step(1'b1, 12'h800, 12'h800, 1'b1, 1'b1, 1'b1, 24'h400000);
        step(1'b1, 12'h800, 12'h7FF, 1'b1, 1'b1, 1'b1, 24'hC00800);
        step(1'b1, 12'hFFF, 12'hFFF, 1'b1, 1'b1, 1'b1, 24'h000001);
        // Mixed mode alternating on identical operands.
        for (int k = 0; k < 6; k++)
            step(1'b1, 12'hFFF, 12'h002, k[0], 1'b1, 1'b1,
                 k[0] ? 24'hFFFFFE : 24'h001FFE);
        drain();

        // Backpressure: fill, stall five cycles while offering new work, release.
        for (int k = 0; k < 4; k++)
            step(1'b1, WA'($urandom), WB'($urandom), 1'($urandom), 1'b1, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, WA'($urandom), WB'($urandom), 1'($urandom), 1'b0, 1'b0, '0);
            chk("stall_in_ready", 64'(in_ready), 64'(0));
            chk("stall_out_valid", 64'(out_valid), 64'(1));
            chk("stall_P", 64'(P), 64'(exp_q[0].p));
        end
        drain();

        // Reset with two transactions in flight.
        step(1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 12'hABC, 12'h321, 1'b1, 1'b1, 1'b0, '0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_P", 64'(P), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 12'h7FF, 12'h801, 1'b1, 1'b1, 1'b0, '0);
        drain();

        // Randomised regression with random valid and backpressure.
        for (int k = 0; k < 3000; k++)
            step($urandom_range(0, 3) != 0, WA'($urandom), WB'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, 1'b0, '0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
